// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB target: byte/counter widths, default bus
// address and the protocol state encoding.
package sccb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;  // holds 0..8 bit positions

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h21;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RD_MACK   = 4'd8,
    S_IGNORE    = 4'd9
  } state_e;

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA lines into clk and derives bus events.
// Ports:
//   clk, rst             system clock, async active-high reset
//   scl_in, sda_in       raw bus lines
//   sda_c                synchronized SDA level
//   scl_rise_c/fall_c    one-clk SCL edge strobes
//   start_c / stop_c     one-clk START / STOP strobes (SDA edge while SCL high)
// SYNC_STAGES is the synchronizer depth; legal range 2..4.
module sccb_bus_sync
  import sccb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_c,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains plus one extra stage of history for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Idle bus level is high, so everything resets to 1 to avoid false events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_c      = sda_s;
  assign scl_rise_c =  scl_s & ~scl_prev_q;
  assign scl_fall_c = ~scl_s &  scl_prev_q;
  // SCL must be high in both samples so an SCL edge never aliases a START/STOP
  assign start_c    = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB (I2C-like) register target. Decodes device address, register pointer
// and write data bytes; optionally serves reads.
// Configuration macro: SCCB_TARGET_READ_EN compiles in the read path; without
// it a read request to this address is NACKed and rd_data is ignored.
// Ports:
//   clk, rst        system clock (>=16x SCL), async active-high reset
//   scl_in, sda_in  bus lines, asynchronous to clk
//   sda_oe          1 = pull SDA low
//   wr_valid        one-clk strobe with wr_reg / wr_data
//   rd_reg          current register pointer
//   rd_data         register contents at rd_reg
//   busy            between START and STOP
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [BYTE_W-1:0] wr_reg,
  output logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_reg,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              busy
);

  logic sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;

  sccb_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_c      (sda_c),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] rd_reg_q, rd_reg_d;
  logic [BYTE_W-1:0] wr_reg_q, wr_reg_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] rx_byte_c;
  logic              byte_done_c;

`ifdef SCCB_TARGET_READ_EN
  logic              rw_q, rw_d;
  logic [BYTE_W-1:0] rd_shift_q, rd_shift_d;
  logic              mack_q, mack_d;
`else
  logic              rd_data_unused;
  assign rd_data_unused = ^rd_data;
`endif

  // Byte as it will look once the current SDA sample is shifted in
  assign rx_byte_c   = {shift_q[BYTE_W-2:0], sda_c};
  assign byte_done_c = (bit_cnt_q == CNT_W'(BYTE_W - 1));

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rd_reg_d   = rd_reg_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
`ifdef SCCB_TARGET_READ_EN
    rw_d       = rw_q;
    rd_shift_d = rd_shift_q;
    mack_d     = mack_q;
`endif

    if (stop_c) begin
      // Any partial byte is dropped; no write strobe is produced
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      // Also covers repeated START from any state
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (byte_done_c) begin
              bit_cnt_d = '0;
              case (state_q)
                S_ADDR: begin
                  if (rx_byte_c[7:1] != DEV_ADDR) begin
                    state_d = S_IGNORE;
`ifdef SCCB_TARGET_READ_EN
                  end else begin
                    state_d = S_ADDR_ACK;
                    rw_d    = rx_byte_c[0];
                  end
`else
                  end else if (rx_byte_c[0]) begin
                    state_d = S_IGNORE;
                  end else begin
                    state_d = S_ADDR_ACK;
                  end
`endif
                end
                S_REG: begin
                  rd_reg_d = rx_byte_c;
                  state_d  = S_REG_ACK;
                end
                default: begin
                  wr_valid_d = 1'b1;
                  wr_reg_d   = rd_reg_q;
                  wr_data_d  = rx_byte_c;
                  rd_reg_d   = rd_reg_q + 8'd1;
                  state_d    = S_WDATA_ACK;
                end
              endcase
            end
          end
        end

        // ACK is asserted on the first SCL fall and released on the second
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = (state_q == S_ADDR_ACK) ? S_REG : S_WDATA;
`ifdef SCCB_TARGET_READ_EN
              if (state_q == S_ADDR_ACK && rw_q) begin
                rd_shift_d = {rd_data[BYTE_W-2:0], 1'b0};
                sda_oe_d   = ~rd_data[BYTE_W-1];
                state_d    = S_RDATA;
              end
`endif
            end
          end
        end

`ifdef SCCB_TARGET_READ_EN
        S_RDATA: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall_c) begin
            if (bit_cnt_q == CNT_W'(BYTE_W)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              mack_d    = 1'b0;
              state_d   = S_RD_MACK;
            end else begin
              sda_oe_d   = ~rd_shift_q[BYTE_W-1];
              rd_shift_d = {rd_shift_q[BYTE_W-2:0], 1'b0};
            end
          end
        end

        // Master ACK advances the pointer; rd_data for the new pointer is
        // then latched on the following SCL fall
        S_RD_MACK: begin
          if (scl_rise_c) begin
            if (sda_c) begin
              state_d = S_IGNORE;
            end else begin
              rd_reg_d = rd_reg_q + 8'd1;
              mack_d   = 1'b1;
            end
          end else if (scl_fall_c && mack_q) begin
            mack_d     = 1'b0;
            rd_shift_d = {rd_data[BYTE_W-2:0], 1'b0};
            sda_oe_d   = ~rd_data[BYTE_W-1];
            bit_cnt_d  = '0;
            state_d    = S_RDATA;
          end
        end
`endif

        S_IGNORE: sda_oe_d = 1'b0;

        default: ;
      endcase
    end
  end

  // State and output registers; reset releases SDA asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rd_reg_q   <= '0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      rw_q       <= 1'b0;
      rd_shift_q <= '0;
      mack_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rd_reg_q   <= rd_reg_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
`ifdef SCCB_TARGET_READ_EN
      rw_q       <= rw_d;
      rd_shift_q <= rd_shift_d;
      mack_q     <= mack_d;
`endif
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign rd_reg   = rd_reg_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: table of write transactions plus hand
// sequences for partial-byte STOP, reset during ACK and (if enabled) reads.
`timescale 1ns/1ps
module tb_sccb_target;

  localparam time CLK_P = 10ns;
  localparam time Q     = 50ns;   // SCL quarter-ish setup/hold
  localparam time H     = 100ns;  // SCL high time

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_reg, wr_data, rd_reg;
  logic [7:0] rd_data = 8'hFF;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] wr_reg_log[$];
  logic [7:0] wr_dat_log[$];
  logic       oe_seen = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  always #(CLK_P/2) clk = ~clk;

  sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_reg_log.push_back(wr_reg);
      wr_dat_log.push_back(wr_data);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_reg_log.delete();
    wr_dat_log.delete();
    oe_seen = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; #H;
    sda_m = 1'b0; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b0; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b1; #H;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #(H/2);
    b = sda_bus; #(H/2);
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] bytes[4];
    int         nbytes;
    int         exp_acks;
    int         exp_wr;
    logic [7:0] exp_reg[2];
    logic [7:0] exp_dat[2];
    logic       exp_oe;
    logic [7:0] exp_ptr;
  } txn_t;

  task automatic apply_txn(input txn_t t);
    int   acks;
    logic a;
    clear_logs();
    acks = 0;
    bus_start();
    check({t.name, " busy_after_start"}, int'(busy), 1);
    for (int i = 0; i < t.nbytes; i++) begin
      write_byte(t.bytes[i], a);
      if (a) acks++;
    end
    bus_stop();
    #(4*CLK_P);
    check({t.name, " acks"}, acks, t.exp_acks);
    check({t.name, " wr_count"}, wr_reg_log.size(), t.exp_wr);
    for (int i = 0; i < t.exp_wr; i++) begin
      if (i < wr_reg_log.size()) begin
        check($sformatf("%s wr_reg[%0d]", t.name, i), int'(wr_reg_log[i]), int'(t.exp_reg[i]));
        check($sformatf("%s wr_data[%0d]", t.name, i), int'(wr_dat_log[i]), int'(t.exp_dat[i]));
      end
    end
    check({t.name, " oe_seen"}, int'(oe_seen), int'(t.exp_oe));
    check({t.name, " busy_after_stop"}, int'(busy), 0);
    check({t.name, " sda_oe_after_stop"}, int'(sda_oe), 0);
    check({t.name, " rd_reg"}, int'(rd_reg), int'(t.exp_ptr));
  endtask

  txn_t vecs[4];

  initial begin
    logic       a;
    logic [7:0] d;
    int         acks;
    bit         got;

    vecs[0] = '{"w_basic", '{8'h42, 8'h12, 8'h80, 8'h00}, 3, 3, 1,
                '{8'h12, 8'h00}, '{8'h80, 8'h00}, 1'b1, 8'h13};
    vecs[1] = '{"w_wrap",  '{8'h42, 8'hFF, 8'hAA, 8'h55}, 4, 4, 2,
                '{8'hFF, 8'h00}, '{8'hAA, 8'h55}, 1'b1, 8'h01};
    vecs[2] = '{"w_other", '{8'h44, 8'h01, 8'h02, 8'h00}, 3, 0, 0,
                '{8'h00, 8'h00}, '{8'h00, 8'h00}, 1'b0, 8'h01};
`ifdef SCCB_TARGET_READ_EN
    vecs[3] = '{"rd_req",  '{8'h43, 8'h00, 8'h00, 8'h00}, 1, 1, 0,
                '{8'h00, 8'h00}, '{8'h00, 8'h00}, 1'b1, 8'h01};
`else
    vecs[3] = '{"rd_req",  '{8'h43, 8'h00, 8'h00, 8'h00}, 1, 0, 0,
                '{8'h00, 8'h00}, '{8'h00, 8'h00}, 1'b0, 8'h01};
`endif

    // Reset values
    #(3*CLK_P);
    @(negedge clk);
    check("rst sda_oe",   int'(sda_oe),   0);
    check("rst wr_valid", int'(wr_valid), 0);
    check("rst wr_reg",   int'(wr_reg),   0);
    check("rst wr_data",  int'(wr_data),  0);
    check("rst rd_reg",   int'(rd_reg),   0);
    check("rst busy",     int'(busy),     0);
    rst = 1'b0;
    #(5*CLK_P);

    for (int i = 0; i < 4; i++) apply_txn(vecs[i]);

    // STOP after 4 bits of a data byte: nothing written, bus idle
    clear_logs();
    bus_start();
    write_byte(8'h42, a);
    write_byte(8'h05, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    #(4*CLK_P);
    check("partial wr_count", wr_reg_log.size(), 0);
    check("partial busy",     int'(busy),   0);
    check("partial sda_oe",   int'(sda_oe), 0);
    check("partial rd_reg",   int'(rd_reg), 8'h05);

    // Reset while the target is driving the address ACK
    clear_logs();
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(d_bit(8'h42, i));
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sda_oe) got = 1'b1;
    end
    check("rstack oe_before", int'(got), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstack oe_async", int'(sda_oe), 0);
    #(3*CLK_P);
    rst = 1'b0;
    scl_m = 1'b1; #H;
    sda_m = 1'b1; #H;
    apply_txn('{"after_rst", '{8'h42, 8'h01, 8'h02, 8'h00}, 3, 3, 1,
                '{8'h01, 8'h00}, '{8'h02, 8'h00}, 1'b1, 8'h02});

`ifdef SCCB_TARGET_READ_EN
    // Register write-address then repeated START into a single-byte read
    clear_logs();
    rd_data = 8'h76;
    acks = 0;
    bus_start();
    write_byte(8'h42, a); if (a) acks++;
    write_byte(8'h0A, a); if (a) acks++;
    bus_rstart();
    write_byte(8'h43, a); if (a) acks++;
    read_byte(d);
    write_bit(1'b1);
    bus_stop();
    #(4*CLK_P);
    check("read acks",     acks, 3);
    check("read data",     int'(d), 8'h76);
    check("read wr_count", wr_reg_log.size(), 0);
    check("read sda_oe",   int'(sda_oe), 0);
    check("read busy",     int'(busy), 0);
    check("read rd_reg",   int'(rd_reg), 8'h0A);
    rd_data = 8'hFF;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic d_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h21, is the 7-bit bus address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on scl_in/sda_in; the legal range is 2..4.
REQ-003 clk  in  1  system clock, at least 16x the SCL rate; the block has one clock, and reset is asynchronous and active-high.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 scl_in  in  1  bus SCL, asynchronous to clk.
REQ-006 sda_in  in  1  bus SDA, asynchronous to clk.
REQ-007 sda_oe  out  1  1 = pull SDA low, 0 = release (open-drain; the pad ties the output to 0).
REQ-008 wr_valid  out  1  one-clk pulse: a write data byte was received.
REQ-009 wr_reg  out  8  register address for wr_data; valid while wr_valid=1.
REQ-010 wr_data  out  8  received data byte; valid while wr_valid=1.
REQ-011 rd_reg  out  8  current register pointer, used for read lookup.
REQ-012 rd_data  in  8  register contents for rd_reg, sampled by the target.
REQ-013 busy  out  1  high from a detected START until a detected STOP.

Function
REQ-014 Edge events: scl_rise, scl_fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high); all are computed from synchronized samples only.
REQ-015 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
REQ-016 Bits are shifted in MSB-first on scl_rise; SDA changes made by the target occur only on scl_fall.
REQ-017 START in any state clears the bit counter and enters ADDR; this covers repeated START.
REQ-018 STOP in any state enters IDLE, forces sda_oe=0 and deasserts busy.
REQ-019 ADDR: after 8 bits, if byte[7:1]==DEV_ADDR the target goes to ADDR_ACK; otherwise it goes to IGNORE and never drives SDA.
REQ-020 ACK drive: sda_oe=1 from the scl_fall following the 8th scl_rise until the next scl_fall.
REQ-021 After ADDR_ACK: R/W=0 goes to REG; R/W=1 goes to RDATA.
REQ-022 REG byte loads the pointer (rd_reg); REG_ACK then goes to WDATA.
REQ-023 WDATA: on the 8th scl_rise, wr_valid pulses for exactly one clk with wr_reg=pointer and wr_data=byte; the target ACKs, increments the pointer modulo 256 (0xFF wraps to 0x00), and returns to WDATA for further bytes.
REQ-024 RDATA: rd_data is latched on the scl_fall that ends ADDR_ACK; for each bit, sda_oe = ~bit, driven from scl_fall.
REQ-025 After 8 read bits, SDA is released and RD_MACK samples the master's bit on scl_rise.
REQ-026 In RD_MACK, master ACK (0) increments the pointer and reloads rd_data for the next byte; master NACK (1) goes to IGNORE.
REQ-027 IGNORE holds sda_oe=0 until START or STOP.
REQ-028 A STOP received during a partial byte discards that byte and produces no wr_valid.

Reset
REQ-029 While rst=1: state=IDLE, sda_oe=0, wr_valid=0, wr_reg=0, wr_data=0, rd_reg=0, busy=0, and synchronizer flops=1.
REQ-030 Reset asserted mid-transfer releases SDA immediately (asynchronously); the first START after reset is decoded normally.

Configuration
REQ-031 Macro SCCB_TARGET_READ_EN: when defined, the read path (REQ-024..026) is compiled in.
REQ-032 When SCCB_TARGET_READ_EN is undefined, an address match with R/W=1 is NACKed and enters IGNORE, and rd_data is unused.

Structure
REQ-033 Shared package sccb_pkg holds the state encoding constants, the byte width (8), and the default DEV_ADDR.
REQ-034 One sub-module, sccb_bus_sync, provides synchronization and scl_rise/scl_fall/START/STOP detection.

Verification
REQ-035 Write 0x42, 0x12, 0x80, then STOP -> 3 ACKs; one wr_valid with wr_reg=0x12 and wr_data=0x80.
REQ-036 Write 0x42, 0xFF, 0xAA, 0x55 -> wr_valid (0xFF, 0xAA) then (0x00, 0x55), confirming pointer wrap.
REQ-037 Address 0x44 followed by two bytes -> sda_oe stays 0 throughout; no wr_valid.
REQ-038 READ_EN: 0x42, 0x0A, repeated START, 0x43 with rd_data=0x76, master NACK -> bus reads 0x76; on return to IDLE sda_oe=0.
REQ-039 STOP after 4 bits of the data byte -> no wr_valid, state IDLE, busy=0.
REQ-040 rst pulse while the target drives ACK -> sda_oe=0 within the same clk; the next 0x42/0x01/0x02 transfer is ACKed and written.
